// File: rtl/noc_ni_rx_if.sv
// Link and stream signals between the LOCAL router port, the NI receiver and the PE.
// master = router/PE environment, slave = noc_ni_rx.
interface noc_ni_rx_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  logic [FLIT_WIDTH-1:0] flit_o;
  logic                  flit_valid_o;
  logic                  flit_ready_i;
  logic                  sop_o;
  logic                  eop_o;
  logic [FLIT_WIDTH-1:0] size_o;
  logic [CNT_WIDTH-1:0]  pkt_count_o;
  logic                  overflow_o;

  modport master (
    output rx, data_i, flit_ready_i,
    input  credit_o, flit_o, flit_valid_o, sop_o, eop_o, size_o, pkt_count_o, overflow_o
  );

  modport slave (
    input  rx, data_i, flit_ready_i,
    output credit_o, flit_o, flit_valid_o, sop_o, eop_o, size_o, pkt_count_o, overflow_o
  );
endinterface

// File: rtl/noc_ni_rx.sv
// NoC network-interface receiver: credit-based flit FIFO plus Hermes packet parser
// (header, size, payload) presenting a ready/valid stream with sop/eop marks.
module noc_ni_rx #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 16,
  parameter int CNT_WIDTH    = 16
) (
  input logic        clock,
  input logic        reset,
  noc_ni_rx_if.slave ni
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_HDR, S_SIZE, S_PAYLOAD} state_t;

  state_t                r_state, w_state_nxt;
  logic [FLIT_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_live;
  logic                  r_overflow;
  logic [FLIT_WIDTH-1:0] r_size, w_size_nxt;
  logic [FLIT_WIDTH-1:0] r_remain, w_remain_nxt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic                  w_credit, w_valid, w_push, w_pop;
  logic                  w_sop, w_eop, w_pkt_done;
  logic [FLIT_WIDTH-1:0] w_head;

  // r_live keeps credit low until the first edge after reset release
  assign w_credit   = r_live && (r_count < CW'(BUFFER_DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_push     = ni.rx && w_credit;
  assign w_pop      = w_valid && ni.flit_ready_i;
  assign w_head     = r_mem[r_rptr];
  assign w_pkt_done = w_pop && w_eop;

  assign ni.credit_o     = w_credit;
  assign ni.flit_o       = w_head;
  assign ni.flit_valid_o = w_valid;
  assign ni.sop_o        = w_sop;
  assign ni.eop_o        = w_eop;
  assign ni.size_o       = r_size;
  assign ni.pkt_count_o  = r_pkt_cnt;
  assign ni.overflow_o   = r_overflow;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= ni.data_i;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_size_nxt   = r_size;
    w_remain_nxt = r_remain;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    case (r_state)
      S_HDR: begin
        w_sop = w_valid;
        if (w_pop) w_state_nxt = S_SIZE;
      end
      S_SIZE: begin
        w_eop = w_valid && (w_head == '0);
        if (w_pop) begin
          w_size_nxt   = w_head;
          w_remain_nxt = w_head;
          w_state_nxt  = (w_head == '0) ? S_HDR : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_eop = w_valid && (r_remain == FLIT_WIDTH'(1));
        if (w_pop) begin
          w_remain_nxt = r_remain - FLIT_WIDTH'(1);
          if (r_remain == FLIT_WIDTH'(1)) w_state_nxt = S_HDR;
        end
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_live     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_state    <= S_HDR;
      r_size     <= '0;
      r_remain   <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (ni.rx && !w_credit) r_overflow <= 1'b1;
      r_state  <= w_state_nxt;
      r_size   <= w_size_nxt;
      r_remain <= w_remain_nxt;
      if (w_pkt_done) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
